// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: FSM state and grant identity.
// The FSM and the muxing parent both import this package.
package pmem_arb;

  typedef enum bit [1:0] {
    idle    = 2'd0,
    serve_i = 2'd1,
    serve_d = 2'd2
  } arb_state_t;

  typedef enum bit {
    icache = 1'b0,
    dcache = 1'b1
  } arb_grant_t;

  function automatic arb_state_t serve_of(input arb_grant_t g);
    return (g == icache) ? serve_i : serve_d;
  endfunction

  // On a tie, the cache that was not served last wins.
  function automatic arb_grant_t rr_pick(input arb_grant_t last);
    return (last == icache) ? dcache : icache;
  endfunction

endpackage

// File: rtl/pmem_arb_fsm.sv
// Grant FSM: tracks which cache owns the memory port and the last cache served.
// A transaction ends only on the adapter's resp, whatever the requester does meanwhile.
module pmem_arb_fsm
  import pmem_arb::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       pmem_resp,
  output arb_state_t state
);

  arb_state_t state_q, state_d;
  arb_grant_t last_q, last_d;

  // last_grant resets to dcache so the icache wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= idle;
      last_q  <= dcache;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      idle: begin
        if (i_req && d_req)
          state_d = serve_of(rr_pick(last_q));
        else if (i_req)
          state_d = serve_i;
        else if (d_req)
          state_d = serve_d;
      end
      serve_i: begin
        if (pmem_resp) begin
          state_d = idle;
          last_d  = icache;
        end
      end
      serve_d: begin
        if (pmem_resp) begin
          state_d = idle;
          last_d  = dcache;
        end
      end
      default: state_d = idle;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one cacheline-adapter port between icache and dcache.
// Request/response muxing only; grant decisions live in pmem_arb_fsm.
module pmem_arbiter
  import pmem_arb::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic                  i_pmem_write,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
  output logic                  i_pmem_resp,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic                  d_pmem_resp,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [LINE_WIDTH-1:0] wdata;
  } req_t;

  arb_state_t state;
  req_t       i_req, d_req, sel;

  assign i_req = '{read: i_pmem_read, write: i_pmem_write,
                   address: i_pmem_address, wdata: i_pmem_wdata};
  assign d_req = '{read: d_pmem_read, write: d_pmem_write,
                   address: d_pmem_address, wdata: d_pmem_wdata};

  pmem_arb_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_pmem_read | i_pmem_write),
    .d_req     (d_pmem_read | d_pmem_write),
    .pmem_resp (pmem_resp),
    .state     (state)
  );

  // Downstream is fully quiet outside a serve state, including during reset.
  always_comb begin
    sel = '0;
    case (state)
      serve_i: sel = i_req;
      serve_d: sel = d_req;
      default: sel = '0;
    endcase
  end

  assign pmem_read    = sel.read;
  assign pmem_write   = sel.write;
  assign pmem_address = sel.address;
  assign pmem_wdata   = sel.wdata;

  // A resp arriving in idle reaches neither cache.
  assign i_pmem_resp  = (state == serve_i) && pmem_resp;
  assign d_pmem_resp  = (state == serve_d) && pmem_resp;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule
